clock_ctrl: RTL and testbench

Mode/set controller for the 24-hour clock datapath. It generates the 1 Hz count enable for the seconds/minutes/hours counter chain and sequences the time-set user interface. MODE steps through RUN -> SET_HOUR -> SET_MIN -> RUN; the SET key produces single or auto-repeat INC pulses to the selected counter. It also provides blink-blanking controls for the display stage.

---
 rtl/clock_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_clock_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_ctrl.sv
// clock_ctrl - mode/set controller for a 24-hour clock datapath.
//
// Purpose:
//   Generates the 1 s count enable for the seconds/minutes/hours counter chain.
//   Sequences the time-set user interface: MODE steps RUN -> SET_HOUR -> SET_MIN
//   -> RUN, and SET produces single or auto-repeat increment pulses to the
//   selected counter. It also drives the blink-blanking controls for the display.
//
// Ports:
//   CLK        system clock
//   RST        synchronous active-high reset
//   KEY_MODE   mode key level (debounced, asynchronous to CLK)
//   KEY_SET    set/increment key level (debounced, asynchronous to CLK)
//   SEC_EN     1-cycle count enable to the seconds counter
//   SEC_CLR    1-cycle clear to the seconds counter (on RUN -> SET_HOUR)
//   MIN_INC    1-cycle increment to the minute counter
//   HOUR_INC   1-cycle increment to the hour counter
//   RUN_MODE   high while in RUN
//   BLANK_H    blank hour digits (blink phase, SET_HOUR only)
//   BLANK_M    blank minute digits (blink phase, SET_MIN only)
//   STATE_DBG  current FSM state (0 RUN, 1 SET_HOUR, 2 SET_MIN)
//
// Output protocol: there is no valid/ready handshake. Every pulse output is a
// registered single-cycle strobe, and the consumer must act on each cycle it
// is high. There is no back-pressure.

module clock_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int BLINK_DIV   = 25000000,
  parameter int REPEAT_DLY  = 25000000,
  parameter int REPEAT_RATE = 5000000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       KEY_MODE,
  input  logic       KEY_SET,
  output logic       SEC_EN,
  output logic       SEC_CLR,
  output logic       MIN_INC,
  output logic       HOUR_INC,
  output logic       RUN_MODE,
  output logic       BLANK_H,
  output logic       BLANK_M,
  output logic [1:0] STATE_DBG
);

  localparam int TW      = $clog2(TICK_DIV);
  localparam int BW      = $clog2(BLINK_DIV) + 1;
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW      = $clog2(REP_MAX + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          mode_s1_q, mode_s2_q, mode_prev_q;
  logic          set_s1_q, set_s2_q, set_prev_q;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic [RW-1:0] rep_q, rep_d;
  logic          sec_en_q, sec_en_d;
  logic          sec_clr_q, sec_clr_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic          run_mode_q, blank_h_q, blank_m_q;

  logic mode_rise, set_rise, tick, state_change, inc_req;

  assign mode_rise = mode_s2_q & ~mode_prev_q;
  assign set_rise  = set_s2_q & ~set_prev_q;
  assign tick      = (cnt_q == TW'(TICK_DIV - 1));

  // Next-state logic for the FSM. MODE rise is the only trigger.
  always_comb begin
    state_d   = state_q;
    sec_clr_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_rise) begin
          state_d   = ST_SET_HOUR;
          sec_clr_d = 1'b1;
        end
      end
      ST_SET_HOUR: if (mode_rise) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (mode_rise) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  assign state_change = (state_d != state_q);

  // Increment generation and auto-repeat. rep_q == 0 means that no repeat is
  // armed. Otherwise the pulse fires when the counter reaches 1. When MODE
  // changes the state in the same cycle, the pulse is dropped (MODE wins).
  always_comb begin
    rep_d   = rep_q;
    inc_req = 1'b0;
    if (state_q == ST_RUN || state_change || !set_s2_q) begin
      rep_d = '0;
    end else if (set_rise) begin
      rep_d   = RW'(REPEAT_DLY);
      inc_req = 1'b1;
    end else if (rep_q == RW'(1)) begin
      rep_d   = RW'(REPEAT_RATE);
      inc_req = 1'b1;
    end else if (rep_q != '0) begin
      rep_d = rep_q - RW'(1);
    end
  end

  always_comb begin
    hour_inc_d = inc_req & (state_q == ST_SET_HOUR);
    min_inc_d  = inc_req & (state_q == ST_SET_MIN);

    // Leaving SET_MIN restarts the second so the first one is full length.
    if (state_q == ST_SET_MIN && mode_rise) cnt_d = '0;
    else if (tick)                          cnt_d = '0;
    else                                    cnt_d = cnt_q + TW'(1);

    // Time stays frozen unless the FSM is in RUN in this cycle and the next.
    sec_en_d = tick & (state_q == ST_RUN) & (state_d == ST_RUN);

    // Digits stay visible on entry to a set state and after each increment.
    if ((state_change && state_d != ST_RUN) || inc_req) begin
      bcnt_d  = '0;
      phase_d = 1'b0;
    end else if (bcnt_q == BW'(BLINK_DIV - 1)) begin
      bcnt_d  = '0;
      phase_d = ~phase_q;
    end else begin
      bcnt_d  = bcnt_q + BW'(1);
      phase_d = phase_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_RUN;
      mode_s1_q   <= 1'b0;
      mode_s2_q   <= 1'b0;
      mode_prev_q <= 1'b0;
      set_s1_q    <= 1'b0;
      set_s2_q    <= 1'b0;
      set_prev_q  <= 1'b0;
      cnt_q       <= '0;
      bcnt_q      <= '0;
      phase_q     <= 1'b0;
      rep_q       <= '0;
      sec_en_q    <= 1'b0;
      sec_clr_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      run_mode_q  <= 1'b1;
      blank_h_q   <= 1'b0;
      blank_m_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_s1_q   <= KEY_MODE;
      mode_s2_q   <= mode_s1_q;
      mode_prev_q <= mode_s2_q;
      set_s1_q    <= KEY_SET;
      set_s2_q    <= set_s1_q;
      set_prev_q  <= set_s2_q;
      cnt_q       <= cnt_d;
      bcnt_q      <= bcnt_d;
      phase_q     <= phase_d;
      rep_q       <= rep_d;
      sec_en_q    <= sec_en_d;
      sec_clr_q   <= sec_clr_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      run_mode_q  <= (state_d == ST_RUN);
      blank_h_q   <= (state_d == ST_SET_HOUR) & phase_d;
      blank_m_q   <= (state_d == ST_SET_MIN) & phase_d;
    end
  end

  assign SEC_EN    = sec_en_q;
  assign SEC_CLR   = sec_clr_q;
  assign MIN_INC   = min_inc_q;
  assign HOUR_INC  = hour_inc_q;
  assign RUN_MODE  = run_mode_q;
  assign BLANK_H   = blank_h_q;
  assign BLANK_M   = blank_m_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl - directed bench for clock_ctrl with
// TICK_DIV=10, BLINK_DIV=5, REPEAT_DLY=20, REPEAT_RATE=4.
//
// Stimulus pushes the expected pulses ({cycle, SEC_EN, SEC_CLR, MIN_INC, HOUR_INC})
// and the expected level snapshots ({cycle, state, RUN_MODE, BLANK_H, BLANK_M})
// into queues. The monitor checks the DUT at each falling edge against these
// queues. Any pulse that no queue entry predicts counts as an error.
// A key driven high at the falling edge with cycle count n gives its registered
// effect at the falling edge with cycle count n+3.

module tb_clock_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       KEY_MODE, KEY_SET;
  logic       SEC_EN, SEC_CLR, MIN_INC, HOUR_INC, RUN_MODE, BLANK_H, BLANK_M;
  logic [1:0] STATE_DBG;

  localparam logic [3:0] P_SEC  = 4'b1000;
  localparam logic [3:0] P_CLR  = 4'b0100;
  localparam logic [3:0] P_MIN  = 4'b0010;
  localparam logic [3:0] P_HOUR = 4'b0001;
  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;

  clock_ctrl #(
    .TICK_DIV(10), .BLINK_DIV(5), .REPEAT_DLY(20), .REPEAT_RATE(4)
  ) dut (
    .CLK(CLK), .RST(RST), .KEY_MODE(KEY_MODE), .KEY_SET(KEY_SET),
    .SEC_EN(SEC_EN), .SEC_CLR(SEC_CLR), .MIN_INC(MIN_INC), .HOUR_INC(HOUR_INC),
    .RUN_MODE(RUN_MODE), .BLANK_H(BLANK_H), .BLANK_M(BLANK_M), .STATE_DBG(STATE_DBG)
  );

  // Clock and the cycle count. cyc is the number of rising edges seen so far.
  always #5 CLK = ~CLK;

  logic [31:0] cyc = 32'd0;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  logic [35:0] exp_q[$];
  logic [36:0] lvl_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        done     = 1'b0;

  task automatic exp_pulse(input logic [31:0] c, input logic [3:0] v);
    exp_q.push_back({c, v});
  endtask

  task automatic exp_lvl(input logic [31:0] c, input logic [1:0] st,
                         input logic run, input logic bh, input logic bm);
    lvl_q.push_back({c, st, run, bh, bm});
  endtask

  task automatic wait_until(input logic [31:0] c);
    while (cyc < c) @(negedge CLK);
  endtask

  task automatic press(input logic m, input logic s, input logic [31:0] len);
    logic [31:0] t0;
    t0 = cyc;
    KEY_MODE = m;
    KEY_SET  = s;
    wait_until(t0 + len);
    KEY_MODE = 1'b0;
    KEY_SET  = 1'b0;
  endtask

  // Monitor and scoreboard.
  always @(negedge CLK) begin
    logic [3:0]  v;
    logic [4:0]  lv;
    logic [35:0] e;
    logic [36:0] l;
    v  = {SEC_EN, SEC_CLR, MIN_INC, HOUR_INC};
    lv = {STATE_DBG, RUN_MODE, BLANK_H, BLANK_M};

    while (exp_q.size() > 0 && exp_q[0][35:4] < cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_pulse: cycle %0d got none, required %b", e[35:4], e[3:0]);
    end
    if (exp_q.size() > 0 && exp_q[0][35:4] == cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      if (v == e[3:0]) n_pass++;
      else $display("FAIL pulse: cycle %0d got %b, required %b", cyc, v, e[3:0]);
    end else if (v != 4'b0000) begin
      n_checks++;
      $display("FAIL unexpected_pulse: cycle %0d got %b, required 0000", cyc, v);
    end

    while (lvl_q.size() > 0 && lvl_q[0][36:5] < cyc) begin
      l = lvl_q.pop_front();
      n_checks++;
      $display("FAIL level_skipped: cycle %0d not sampled, required %b", l[36:5], l[4:0]);
    end
    if (lvl_q.size() > 0 && lvl_q[0][36:5] == cyc) begin
      l = lvl_q.pop_front();
      n_checks++;
      if (lv == l[4:0]) n_pass++;
      else $display("FAIL level{st,run,bh,bm}: cycle %0d got %b, required %b", cyc, lv, l[4:0]);
    end

    if (done) begin
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        $display("FAIL missing_pulse_at_end: cycle %0d got none, required %b", e[35:4], e[3:0]);
      end
      while (lvl_q.size() > 0) begin
        l = lvl_q.pop_front();
        n_checks++;
        $display("FAIL level_unchecked_at_end: cycle %0d, required %b", l[36:5], l[4:0]);
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  // Directed stimulus.
  initial begin
    logic [31:0] r, d, s, m;
    RST = 1'b1; KEY_MODE = 1'b0; KEY_SET = 1'b0;

    // Reset state.
    exp_lvl(32'd3, S_RUN, 1'b1, 1'b0, 1'b0);
    wait_until(32'd5);
    RST = 1'b0;
    r = cyc;

    // 1: free-running RUN, SEC_EN every 10 cycles.
    for (int k = 1; k <= 10; k++) exp_pulse(r + 32'(10 * k), P_SEC);
    exp_lvl(r + 50, S_RUN, 1'b1, 1'b0, 1'b0);
    wait_until(r + 101);

    // 2: MODE -> SET_HOUR with SEC_CLR. BLANK_H blinks 5 visible / 5 blank.
    d = cyc;
    exp_pulse(d + 3, P_CLR);
    for (logic [31:0] c = d + 3; c < d + 23; c++)
      exp_lvl(c, S_HOUR, 1'b0, (((c - d - 3) / 5) % 2) == 1, 1'b0);
    press(1'b1, 1'b0, 3);
    wait_until(d + 203);

    // 3: single HOUR_INC. The blink restarts visible. Then go to SET_MIN and
    // give a single MIN_INC.
    s = cyc;
    exp_pulse(s + 3, P_HOUR);
    exp_lvl(s + 3, S_HOUR, 1'b0, 1'b0, 1'b0);
    exp_lvl(s + 8, S_HOUR, 1'b0, 1'b1, 1'b0);
    press(1'b0, 1'b1, 3);
    wait_until(s + 10);
    m = cyc;
    exp_lvl(m + 3, S_MIN, 1'b0, 1'b0, 1'b0);
    exp_lvl(m + 8, S_MIN, 1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b0, 3);
    wait_until(m + 10);
    s = cyc;
    exp_pulse(s + 3, P_MIN);
    press(1'b0, 1'b1, 3);
    wait_until(s + 10);

    // 4: hold SET for 46 cycles. Pulses come at t0, t0+20, then every 4 up to
    // t0+44. The release stops any further pulses.
    s = cyc;
    exp_pulse(s + 3, P_MIN);
    for (int j = 0; j < 7; j++) exp_pulse(s + 32'(23 + 4 * j), P_MIN);
    press(1'b0, 1'b1, 46);
    wait_until(s + 80);

    // 5: MODE -> RUN. The first SEC_EN comes 10 cycles after entry. Back to
    // SET_HOUR. Then MODE and SET together go to SET_MIN with no INC. Then RUN.
    m = cyc;
    exp_lvl(m + 3, S_RUN, 1'b1, 1'b0, 1'b0);
    exp_pulse(m + 13, P_SEC);
    exp_pulse(m + 23, P_SEC);
    press(1'b1, 1'b0, 3);
    wait_until(m + 25);
    m = cyc;
    exp_pulse(m + 3, P_CLR);
    exp_lvl(m + 4, S_HOUR, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 3);
    wait_until(m + 10);
    m = cyc;
    exp_lvl(m + 3, S_MIN, 1'b0, 1'b0, 1'b0);
    exp_lvl(m + 8, S_MIN, 1'b0, 1'b0, 1'b1);
    press(1'b1, 1'b1, 3);
    wait_until(m + 10);
    m = cyc;
    exp_lvl(m + 3, S_RUN, 1'b1, 1'b0, 1'b0);
    exp_pulse(m + 13, P_SEC);
    exp_pulse(m + 23, P_SEC);
    press(1'b1, 1'b0, 3);
    wait_until(m + 25);

    // 6: reach SET_MIN and hold SET. RST during auto-repeat cancels the pulse
    // due at s+31. SET held in RUN after reset produces nothing.
    m = cyc;
    exp_pulse(m + 3, P_CLR);
    press(1'b1, 1'b0, 3);
    wait_until(m + 10);
    press(1'b1, 1'b0, 3);
    wait_until(m + 20);
    s = cyc;
    exp_pulse(s + 3, P_MIN);
    exp_pulse(s + 23, P_MIN);
    exp_pulse(s + 27, P_MIN);
    KEY_SET = 1'b1;
    wait_until(s + 30);
    exp_lvl(s + 31, S_RUN, 1'b1, 1'b0, 1'b0);
    RST = 1'b1;
    wait_until(s + 31);
    RST = 1'b0;
    r = cyc;
    exp_pulse(r + 10, P_SEC);
    exp_pulse(r + 20, P_SEC);
    exp_lvl(r + 12, S_RUN, 1'b1, 1'b0, 1'b0);
    wait_until(s + 60);
    KEY_SET = 1'b0;
    wait_until(r + 25);
    done = 1'b1;
  end

endmodule
